// File: rtl/flex_enable_sync_pkg.sv
// flex_enable_sync_pkg: shared state type, edge-mode codes and counter sizing
package flex_enable_pkg;
  typedef enum logic [1:0] {IDLE, PULSE, HOLDOFF} en_state_t;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_BOTH = 2;
  function automatic int cnt_width(input int p, input int h);
    return $clog2((p > h ? p : h) + 1);
  endfunction
endpackage

// File: rtl/flex_enable_sync_if.sv
// flex_enable_sync_if: enable-converter bus between slow control sources and the datapath
interface flex_enable_sync_if #(parameter int NUM_CH = 4);
  logic [NUM_CH-1:0] slow_enable;
  logic [NUM_CH-1:0] ch_mask;
  logic              clear_overrun;
  logic [NUM_CH-1:0] fast_enable;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] overrun;
  modport master(output slow_enable, ch_mask, clear_overrun, input fast_enable, busy, overrun);
  modport slave(input slow_enable, ch_mask, clear_overrun, output fast_enable, busy, overrun);
endinterface

// File: rtl/flex_enable_sync_chan.sv
// enable_sync_chan: one channel - synchroniser, priming, edge detect and pulse/holdoff FSM
module enable_sync_chan
  import flex_enable_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = 0,
  parameter int PULSE_LEN   = 1,
  parameter int HOLDOFF     = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_slow_enable,
  input  logic i_ch_mask,
  input  logic i_clear_overrun,
  output logic o_fast_enable,
  output logic o_busy,
  output logic o_overrun
);
  localparam int CW = cnt_width(PULSE_LEN, HOLDOFF);
  localparam int PW = $clog2(SYNC_STAGES + 2);
  localparam logic [PW-1:0] PRIME_DONE = PW'(SYNC_STAGES + 1);
  localparam logic [CW-1:0] PULSE_LOAD = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLDOFF > 0 ? HOLDOFF - 1 : 0);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   r_edge;
  logic [PW-1:0]          r_prime;
  logic [CW-1:0]          r_cnt;
  logic [CW-1:0]          w_cnt_nxt;
  logic                   r_ovr;
  en_state_t              r_state;
  en_state_t              w_state_nxt;
  logic                   w_sync_out;
  logic                   w_primed;
  logic                   w_edge;
  logic                   w_take;
  assign w_sync_out = r_sync[SYNC_STAGES-1];
  assign w_primed   = r_prime == PRIME_DONE;
  assign w_edge     = EDGE_MODE == EDGE_FALL ? ~w_sync_out & r_prev :
                      EDGE_MODE == EDGE_BOTH ? w_sync_out ^ r_prev : w_sync_out & ~r_prev;
  assign w_take     = r_edge & i_ch_mask;
  // synchronise the level, track the previous sample and hold off detection until the chain has flushed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= '0;
      r_prev  <= 1'b0;
      r_edge  <= 1'b0;
      r_prime <= '0;
    end else begin
      r_sync  <= {r_sync[SYNC_STAGES-2:0], i_slow_enable};
      r_prev  <= w_sync_out;
      r_edge  <= w_primed & w_edge;
      r_prime <= w_primed ? r_prime : r_prime + PW'(1);
    end
  end
  // FSM state and countdown register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
  // next state: start a pulse from IDLE only, count the pulse then the optional holdoff gap
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: if (w_take) begin
        w_state_nxt = PULSE;
        w_cnt_nxt   = PULSE_LOAD;
      end
      PULSE: if (r_cnt == '0) begin
        w_state_nxt = HOLDOFF == 0 ? IDLE : flex_enable_pkg::HOLDOFF;
        w_cnt_nxt   = HOLD_LOAD;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      flex_enable_pkg::HOLDOFF: if (r_cnt == '0) begin
        w_state_nxt = IDLE;
      end else begin
        w_cnt_nxt = r_cnt - CW'(1);
      end
      default: w_state_nxt = IDLE;
    endcase
  end
  // outputs decode straight from the state register
  always_comb begin
    o_fast_enable = r_state == PULSE;
    o_busy        = r_state != IDLE;
  end
  // sticky overrun for edges dropped while busy; a new drop beats a simultaneous clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_ovr <= 1'b0;
    else     r_ovr <= (w_take & o_busy) | (r_ovr & ~i_clear_overrun);
  end
  assign o_overrun = r_ovr;
endmodule

// File: rtl/flex_enable_sync.sv
// flex_enable_sync: multi-channel slow-to-fast enable converter with pulse stretch and holdoff
module flex_enable_sync
  import flex_enable_pkg::*;
#(
  parameter int NUM_CH      = 4,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_MODE   = EDGE_RISE,
  parameter int PULSE_LEN   = 1,
  parameter int HOLDOFF     = 0
) (
  input logic clk,
  input logic rst,
  flex_enable_sync_if.slave bus
);
  logic w_clear;
  assign w_clear = bus.clear_overrun;
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    enable_sync_chan #(
      .SYNC_STAGES(SYNC_STAGES),
      .EDGE_MODE  (EDGE_MODE),
      .PULSE_LEN  (PULSE_LEN),
      .HOLDOFF    (HOLDOFF)
    ) u_chan (
      .clk            (clk),
      .rst            (rst),
      .i_slow_enable  (bus.slow_enable[c]),
      .i_ch_mask      (bus.ch_mask[c]),
      .i_clear_overrun(w_clear),
      .o_fast_enable  (bus.fast_enable[c]),
      .o_busy         (bus.busy[c]),
      .o_overrun      (bus.overrun[c])
    );
  end
endmodule

// File: tb/tb_flex_enable_sync.sv
// tb_flex_enable_sync: three configurations driven in lockstep, checked against a timeline model
module tb_flex_enable_sync;
  localparam int NC = 4;
  localparam int SS [3] = '{2, 3, 2};
  localparam int EM [3] = '{0, 1, 2};
  localparam int PL [3] = '{1, 3, 2};
  localparam int HO [3] = '{0, 4, 1};
  typedef struct {
    int k;
    logic [2:0][11:0] v;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  flex_enable_sync_if #(.NUM_CH(NC)) ifa ();
  flex_enable_sync_if #(.NUM_CH(NC)) ifb ();
  flex_enable_sync_if #(.NUM_CH(NC)) ifc ();
  flex_enable_sync #(.NUM_CH(NC), .SYNC_STAGES(2), .EDGE_MODE(0), .PULSE_LEN(1), .HOLDOFF(0))
    dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
  flex_enable_sync #(.NUM_CH(NC), .SYNC_STAGES(3), .EDGE_MODE(1), .PULSE_LEN(3), .HOLDOFF(4))
    dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
  flex_enable_sync #(.NUM_CH(NC), .SYNC_STAGES(2), .EDGE_MODE(2), .PULSE_LEN(2), .HOLDOFF(1))
    dut_c (.clk(clk), .rst(rst), .bus(ifc.slave));
  exp_t sb[$];
  logic [NC-1:0] hist[$];
  int k;
  int start [3][NC];
  int bend [3][NC];
  bit ovr [3][NC];
  logic [NC-1:0] last_fe_b;
  int n_vec = 0;
  int n_miss = 0;
  function automatic logic [11:0] act(input int d);
    return d == 0 ? {ifa.overrun, ifa.busy, ifa.fast_enable} :
           d == 1 ? {ifb.overrun, ifb.busy, ifb.fast_enable} :
                    {ifc.overrun, ifc.busy, ifc.fast_enable};
  endfunction
  function automatic bit in_at(input int j, input int c);
    return j < 1 ? 1'b0 : hist[j-1][c];
  endfunction
  function automatic bit edge_of(input int mode, input bit cur, input bit prv);
    return mode == 0 ? (cur && !prv) : mode == 1 ? (!cur && prv) : (cur != prv);
  endfunction
  task automatic drive(input logic [NC-1:0] se, input logic [NC-1:0] msk, input bit clr);
    ifa.slow_enable = se; ifb.slow_enable = se; ifc.slow_enable = se;
    ifa.ch_mask = msk; ifb.ch_mask = msk; ifc.ch_mask = msk;
    ifa.clear_overrun = clr; ifb.clear_overrun = clr; ifc.clear_overrun = clr;
  endtask
  task automatic model_clear();
    hist.delete();
    k = 0;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NC; c++) begin
        start[d][c] = -1000;
        bend[d][c] = 0;
        ovr[d][c] = 1'b0;
      end
    last_fe_b = '0;
  endtask
  // inputs for the next rising edge k; predicts every output as seen just after edge k
  task automatic step(input logic [NC-1:0] se, input logic [NC-1:0] msk, input bit clr);
    exp_t e;
    drive(se, msk, clr);
    hist.push_back(se);
    k++;
    e.k = k;
    for (int d = 0; d < 3; d++)
      for (int c = 0; c < NC; c++) begin
        int j = k - 1;
        bit ed, set;
        ed = (j >= SS[d] + 2) && edge_of(EM[d], in_at(j - SS[d], c), in_at(j - SS[d] - 1, c));
        set = 1'b0;
        if (ed && msk[c]) begin
          if (j >= bend[d][c]) begin
            start[d][c] = k;
            bend[d][c] = k + PL[d] + HO[d];
          end else set = 1'b1;
        end
        ovr[d][c] = set | (ovr[d][c] & !clr);
        e.v[d][c]     = k >= start[d][c] && k < start[d][c] + PL[d];
        e.v[d][4 + c] = k >= start[d][c] && k < bend[d][c];
        e.v[d][8 + c] = ovr[d][c];
      end
    last_fe_b = e.v[1][3:0];
    sb.push_back(e);
  endtask
  task automatic do_reset(input logic [NC-1:0] se);
    rst = 1'b1;
    drive(se, '1, 1'b0);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_vec++;
      if (act(d) !== 12'h0) begin
        n_miss++;
        $display("FAIL reset_dut%0d: got %h want 000", d, act(d));
      end
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_clear();
    step(se, '1, 1'b0);
  endtask
  task automatic rand_step(inout logic [NC-1:0] se, input int tog, input int mrate, input int crate);
    logic [NC-1:0] msk;
    for (int c = 0; c < NC; c++) begin
      if ($urandom_range(0, tog - 1) == 0) se[c] = ~se[c];
      msk[c] = $urandom_range(0, mrate - 1) != 0;
    end
    step(se, msk, $urandom_range(0, crate - 1) == 0);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        for (int d = 0; d < 3; d++) begin
          n_vec++;
          if (act(d) !== e.v[d]) begin
            n_miss++;
            $display("FAIL dut%0d_cycle%0d: ovr/busy/fe got %h want %h", d, e.k, act(d), e.v[d]);
          end
        end
      end
    end
  end
  initial begin : stim
    logic [NC-1:0] se;
    bit hit;
    model_clear();
    do_reset('0);
    repeat (8) begin @(negedge clk); step('0, '1, 1'b0); end
    repeat (12) begin @(negedge clk); step(4'h1, '1, 1'b0); end
    @(negedge clk);
    do_reset('1);
    repeat (15) begin @(negedge clk); step('1, '1, 1'b0); end
    repeat (4) begin @(negedge clk); step(4'hD, '1, 1'b0); end
    repeat (15) begin @(negedge clk); step('1, '1, 1'b0); end
    repeat (6) begin @(negedge clk); step('0, 4'h7, 1'b0); end
    repeat (30) begin @(negedge clk); step(($urandom_range(0, 1) != 0) ? 4'hF : 4'h0, 4'h7, 1'b0); end
    se = '0;
    repeat (600) begin @(negedge clk); rand_step(se, 6, 8, 20); end
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      @(negedge clk);
      if (last_fe_b != '0) begin
        hit = 1'b1;
        se = 4'($urandom);
        do_reset(se);
      end else rand_step(se, 3, 8, 50);
    end
    if (!hit) begin
      n_vec++;
      n_miss++;
      $display("FAIL midpulse_reset: got no pulse on dut1 want one within 300 cycles");
    end
    repeat (400) begin @(negedge clk); rand_step(se, 2, 6, 10); end
    repeat (20) begin @(negedge clk); step(se, '1, 1'b1); end
    @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
